grom_io_input: RTL and testbench

//  CPU-side input port: the read counterpart of the display output register.
//  An external byte source pushes bytes through a valid/ready handshake into a small FIFO.
//  The grom CPU pulls bytes out with IO reads (ioreq=1, we=0) and polls a status port.

---
 rtl/grom_io_input.sv | 110 +++++++++++
 tb/tb_grom_io_input.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/grom_io_input.sv
// grom_io_input: CPU-side byte input port for the grom computer.
// An external source pushes bytes into a small FIFO via valid/ready; the CPU
// pops them with edge-triggered IO reads of DATA_PORT and polls STATUS_PORT.
// A write of bit0=1 to STATUS_PORT flushes the FIFO.
module grom_io_input #(
   parameter int         DEPTH       = 4,
   parameter logic [7:0] DATA_PORT   = 8'h00,
   parameter logic [7:0] STATUS_PORT = 8'h01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] addr,
   input  logic        ioreq,
   input  logic        we,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  data_out,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        data_avail
);

   localparam int         PW      = $clog2(DEPTH);
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [3:0]    count;
   logic          rd_q;

   logic [7:0]    port;
   logic          rd_req;
   logic          rd_stb;
   logic          flush;
   logic          full;
   logic          push;
   logic          pop;
   logic [7:0]    status;

   // Decode the CPU cycle and derive the single-shot read strobe and FIFO moves.
   always_comb begin
      port       = addr[7:0];
      rd_req     = ioreq & ~we;
      rd_stb     = rd_req & ~rd_q;
      flush      = ioreq & we & (port == STATUS_PORT) & cpu_din[0];
      full       = (count == DEPTH_C);
      in_ready   = ~full;
      data_avail = (count != 4'd0);
      // A flush in the same cycle wins over an incoming byte.
      push       = in_valid & ~full & ~flush;
      // Reading an empty FIFO returns zero and leaves the pointers alone.
      pop        = rd_stb & (port == DATA_PORT) & data_avail;
      status     = {count, 2'b00, full, data_avail};
   end

   // FIFO storage write port.
   // NOTE: the storage array has no reset; its contents are meaningless while
   // count is zero, so clearing it would only add logic.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointer, occupancy and read-edge tracking.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= 4'd0;
         rd_q   <= 1'b0;
      end else begin
         rd_q <= rd_req;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + 4'd1;
               2'b01:   count <= count - 4'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // Registered read data: updated only on a read strobe to a known port.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_out <= 8'h00;
      end else if (rd_stb) begin
         if (port == DATA_PORT) begin
            data_out <= pop ? mem[rd_ptr] : 8'h00;
         end else if (port == STATUS_PORT) begin
            data_out <= status;
         end
      end
   end

endmodule

// File: tb/tb_grom_io_input.sv
// Self-checking bench for grom_io_input: a queue-based reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_grom_io_input;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic [11:0] addr;
   logic        ioreq;
   logic        we;
   logic [7:0]  cpu_din;
   logic [7:0]  data_out;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        data_avail;

   int n_checks = 0;
   int n_fail   = 0;

   grom_io_input #(.DEPTH(DEPTH), .DATA_PORT(8'h00), .STATUS_PORT(8'h01)) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .ioreq      (ioreq),
      .we         (we),
      .cpu_din    (cpu_din),
      .data_out   (data_out),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_avail (data_avail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   byte unsigned q[$];
   logic [7:0]   m_dout;
   logic         m_prev_req;

   function automatic logic [7:0] model_status();
      logic [3:0] sc;
      sc = 4'(q.size());
      return {sc, 2'b00, (q.size() == DEPTH), (q.size() != 0)};
   endfunction

   task automatic model_step();
      logic       req;
      logic       stb;
      logic       fl;
      logic       room;
      logic [7:0] p;
      if (reset) begin
         q.delete();
         m_dout     = 8'h00;
         m_prev_req = 1'b0;
         return;
      end
      p    = addr[7:0];
      req  = ioreq & ~we;
      stb  = req & ~m_prev_req;
      m_prev_req = req;
      fl   = ioreq & we & (p == 8'h01) & cpu_din[0];
      room = (q.size() < DEPTH);
      if (stb && p == 8'h00) begin
         if (q.size() > 0) m_dout = q.pop_front();
         else              m_dout = 8'h00;
      end else if (stb && p == 8'h01) begin
         m_dout = model_status();
      end
      if (fl) q.delete();
      else if (in_valid && room) q.push_back(in_data);
   endtask

   // Model advances on each rising edge; DUT outputs compared on the falling edge.
   always begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("data_out",   data_out,            m_dout);
      check("in_ready",   {7'b0, in_ready},    {7'b0, (q.size() < DEPTH)});
      check("data_avail", {7'b0, data_avail},  {7'b0, (q.size() != 0)});
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_read(input logic [7:0] port, output logic [7:0] val);
      addr  = {4'h0, port};
      ioreq = 1'b1;
      we    = 1'b0;
      tick();
      val   = data_out;
      ioreq = 1'b0;
      tick();
   endtask

   task automatic cpu_write(input logic [7:0] port, input logic [7:0] d);
      addr    = {4'h0, port};
      cpu_din = d;
      ioreq   = 1'b1;
      we      = 1'b1;
      tick();
      ioreq   = 1'b0;
      we      = 1'b0;
   endtask

   task automatic push(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   logic [7:0] v;

   initial begin
      reset = 1'b1; addr = '0; ioreq = 1'b0; we = 1'b0; cpu_din = '0;
      in_data = '0; in_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();

      // 1: reset state
      cpu_read(8'h01, v);
      check("t1_status", v, 8'h00);
      check("t1_in_ready", {7'b0, in_ready}, 8'h01);
      check("t1_avail", {7'b0, data_avail}, 8'h00);

      // 2: two bytes in, two separate reads out
      push(8'hA5); push(8'h3C);
      cpu_read(8'h00, v); check("t2_first", v, 8'hA5);
      cpu_read(8'h00, v); check("t2_second", v, 8'h3C);
      cpu_read(8'h01, v); check("t2_status", v, 8'h00);

      // 3: fill to DEPTH; status {4, 00, full=1, avail=1}
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      check("t3_in_ready", {7'b0, in_ready}, 8'h00);
      cpu_read(8'h01, v); check("t3_status_full", v, 8'h43);
      push(8'h99);
      cpu_read(8'h01, v); check("t3_status_after5", v, 8'h43);
      cpu_read(8'h00, v); check("t3_pop", v, 8'h11);
      check("t3_in_ready2", {7'b0, in_ready}, 8'h01);
      cpu_read(8'h01, v); check("t3_status_3", v, 8'h31);
      cpu_read(8'h00, v); check("t3_d2", v, 8'h22);
      cpu_read(8'h00, v); check("t3_d3", v, 8'h33);
      cpu_read(8'h00, v); check("t3_d4", v, 8'h44);

      // 4: a read held for 5 cycles pops exactly once
      push(8'h5A); push(8'h6B);
      addr = 12'h000; ioreq = 1'b1; we = 1'b0;
      repeat (5) tick();
      ioreq = 1'b0;
      check("t4_held_data", data_out, 8'h5A);
      tick();
      cpu_read(8'h01, v); check("t4_status", v, 8'h11);
      cpu_read(8'h00, v); check("t4_rest", v, 8'h6B);

      // 5: empty read, then push+pop on an empty FIFO
      cpu_read(8'h00, v); check("t5_empty", v, 8'h00);
      in_data = 8'h77; in_valid = 1'b1; addr = 12'h000; ioreq = 1'b1; we = 1'b0;
      tick();
      in_valid = 1'b0; ioreq = 1'b0;
      check("t5_pushpop_data", data_out, 8'h00);
      tick();
      cpu_read(8'h01, v); check("t5_status", v, 8'h11);
      cpu_read(8'h00, v); check("t5_kept", v, 8'h77);

      // 6: flush with a concurrent push, then pointer wrap
      push(8'h01); push(8'h02); push(8'h03);
      in_data = 8'hEE; in_valid = 1'b1;
      cpu_write(8'h01, 8'h01);
      in_valid = 1'b0;
      check("t6_avail", {7'b0, data_avail}, 8'h00);
      cpu_read(8'h01, v); check("t6_status", v, 8'h00);
      cpu_write(8'h01, 8'h00);  // bit0 clear: ignored
      cpu_write(8'h05, 8'h01);  // other port: ignored
      push(8'hC0);
      for (int i = 0; i < 6; i++) begin
         push(8'hD0 + 8'(i));
         cpu_read(8'h00, v);
         check("t6_wrap_order", v, (i == 0) ? 8'hC0 : 8'hD0 + 8'(i - 1));
      end
      cpu_read(8'h00, v); check("t6_wrap_last", v, 8'hD5);

      // Reset mid-operation with a status read held across release
      push(8'h12); push(8'h34);
      reset = 1'b1; addr = 12'h001; ioreq = 1'b1; we = 1'b0;
      tick(); tick();
      check("rst_data_out", data_out, 8'h00);
      reset = 1'b0; in_data = 8'h56; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; ioreq = 1'b0;
      check("rst_release_status", data_out, 8'h00);
      tick();
      cpu_read(8'h00, v); check("rst_new_byte", v, 8'h56);

      // Random traffic checked by the model every cycle
      for (int i = 0; i < 600; i++) begin
         ioreq    = ($urandom_range(0, 2) == 0);
         we       = ($urandom_range(0, 3) == 0);
         addr     = {4'($urandom), 8'($urandom_range(0, 2))};
         cpu_din  = {7'($urandom), ($urandom_range(0, 7) == 0)};
         in_valid = ($urandom_range(0, 1) == 1);
         in_data  = 8'($urandom);
         reset    = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset = 1'b0; ioreq = 1'b0; we = 1'b0; in_valid = 1'b0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
